// File: rtl/store_unit_pkg.sv
// Shared definitions for the MEM-stage store and load paths: access size
// encodings and the store request state machine encoding.
package store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } st_state_e;

endpackage

// File: rtl/store_unit_if.sv
// Pipeline-side store request plus data-memory write channel. dm_req/dm_ack:
// the request holds address, data and strobes stable until dm_ack is seen high
// on a rising edge while dm_req=1; an ack while dm_req=0 carries no meaning.
interface store_unit_if;
    logic        st_valid;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_stall;
    logic        st_ades;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ack;

    modport slave (
        input  st_valid, st_size, st_addr, st_data, dm_ack,
        output st_stall, st_ades, dm_req, dm_addr, dm_wdata, dm_wstrb
    );

    modport master (
        output st_valid, st_size, st_addr, st_data, dm_ack,
        input  st_stall, st_ades, dm_req, dm_addr, dm_wdata, dm_wstrb
    );
endinterface

// File: rtl/store_align.sv
// Little-endian lane formatting for sb/sh/sw: replicates the narrow value onto
// every lane and selects the byte strobes from the low address bits.
module store_align
    import store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned
);

    always_comb begin
        wdata      = data;
        wstrb      = 4'b0000;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                wdata      = {2{data[15:0]}};
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            SZ_WORD: begin
                wstrb      = 4'b1111;
                misaligned = |addr_lo;
            end
            default: begin
                wstrb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store path: validates the store, formats lanes, and runs a single
// outstanding req/ack write to data memory while stalling the pipeline.
module store_unit
    import store_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    store_unit_if.slave     su,
    output st_state_e       dbg_state
);

    st_state_e   state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_wstrb_q, dm_wstrb_d;

    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic        al_misaligned;
    logic        shape_ok;
    logic        in_idle;
    logic        accept;

    store_align u_align (
        .size       (su.st_size),
        .addr_lo    (su.st_addr[1:0]),
        .data       (su.st_data),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .misaligned (al_misaligned)
    );

    // Only IDLE may accept or fault; REQ and DONE ignore the held instruction.
    assign shape_ok = (su.st_size != SZ_RSVD) && !al_misaligned;
    assign in_idle  = (state_q == ST_IDLE);
    assign accept   = in_idle && su.st_valid && shape_ok;

    assign su.st_ades  = in_idle && su.st_valid && !shape_ok;
    assign su.st_stall = accept || (state_q == ST_REQ);
    assign su.dm_req   = dm_req_q;
    assign su.dm_addr  = dm_addr_q;
    assign su.dm_wdata = dm_wdata_q;
    assign su.dm_wstrb = dm_wstrb_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_wstrb_d = dm_wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_REQ;
                    dm_req_d   = 1'b1;
                    dm_addr_d  = {su.st_addr[31:2], 2'b00};
                    dm_wdata_d = al_wdata;
                    dm_wstrb_d = al_wstrb;
                end
            end
            ST_REQ: begin
                if (su.dm_ack) begin
                    state_d  = ST_DONE;
                    dm_req_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dm_req_q   <= 1'b0;
            dm_addr_q  <= 32'd0;
            dm_wdata_q <= 32'd0;
            dm_wstrb_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_wstrb_q <= dm_wstrb_d;
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed and random stores checked against a byte-addressed reference memory
// and a lane model derived from little-endian byte placement.
module tb_store_unit;
  import store_unit_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  st_state_e dbg_state;
  int        n_pass = 0;
  int        n_total = 0;

  logic [7:0] ref_mem [64];
  logic [7:0] dut_mem [64];

  store_unit_if bus ();

  store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .su        (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_legal(input logic [1:0] sz, input logic [31:0] a);
    int n = size_bytes(sz);
    return (sz != 2'd3) && ((a % n) == 0);
  endfunction

  // Lane i carries data byte (i mod n); it is enabled when it falls inside [a, a+n).
  task automatic exp_lanes(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] w, output logic [3:0] s);
    int n = size_bytes(sz);
    int off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = d[8*(i % n) +: 8];
      s[i] = (i >= off) && (i < off + n);
    end
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input int delay);
    logic [31:0] ew;
    logic [3:0]  es;
    int          stall_cnt;
    int          n;
    @(posedge clk); #1;
    bus.st_valid = 1'b1;
    bus.st_size  = sz;
    bus.st_addr  = a;
    bus.st_data  = d;
    #1;
    if (!is_legal(sz, a)) begin
      check("ades_illegal", {31'd0, bus.st_ades}, 32'd1);
      check("stall_illegal", {31'd0, bus.st_stall}, 32'd0);
      check("req_illegal", {31'd0, bus.dm_req}, 32'd0);
      @(posedge clk); #1;
      bus.st_valid = 1'b0;
      #1;
      check("req_after_illegal", {31'd0, bus.dm_req}, 32'd0);
      check("state_after_illegal", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      return;
    end
    exp_lanes(sz, a, d, ew, es);
    n = size_bytes(sz);
    for (int j = 0; j < n; j++) ref_mem[(a + j) & 63] = d[8*j +: 8];
    stall_cnt = 0;
    check("accept_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("accept_stall", {31'd0, bus.st_stall}, 32'd1);
    check("accept_ades", {31'd0, bus.st_ades}, 32'd0);
    stall_cnt += int'(bus.st_stall);
    for (int k = 0; k <= delay; k++) begin
      @(posedge clk); #1;
      bus.dm_ack = (k == delay);
      #1;
      check("req_high", {31'd0, bus.dm_req}, 32'd1);
      check("dm_addr", bus.dm_addr, {a[31:2], 2'b00});
      check("dm_wdata", bus.dm_wdata, ew);
      check("dm_wstrb", {28'd0, bus.dm_wstrb}, {28'd0, es});
      check("ades_in_req", {31'd0, bus.st_ades}, 32'd0);
      stall_cnt += int'(bus.st_stall);
    end
    for (int i = 0; i < 4; i++)
      if (bus.dm_wstrb[i]) dut_mem[(bus.dm_addr + i) & 63] = bus.dm_wdata[8*i +: 8];
    @(posedge clk); #1;
    bus.dm_ack = 1'b0;
    #1;
    check("done_state", {30'd0, dbg_state}, {30'd0, ST_DONE});
    check("done_req", {31'd0, bus.dm_req}, 32'd0);
    check("done_stall", {31'd0, bus.st_stall}, 32'd0);
    stall_cnt += int'(bus.st_stall);
    check("stall_cycles", stall_cnt, 2 + delay);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    #1;
    check("idle_req", {31'd0, bus.dm_req}, 32'd0);
    check("idle_stall", {31'd0, bus.st_stall}, 32'd0);
  endtask

  initial begin
    bus.st_valid = 1'b0;
    bus.st_size  = 2'd0;
    bus.st_addr  = 32'd0;
    bus.st_data  = 32'd0;
    bus.dm_ack   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 8'd0;
      dut_mem[i] = 8'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rst_req", {31'd0, bus.dm_req}, 32'd0);
    check("rst_addr", bus.dm_addr, 32'd0);
    check("rst_wdata", bus.dm_wdata, 32'd0);
    check("rst_wstrb", {28'd0, bus.dm_wstrb}, 32'd0);
    check("rst_stall", {31'd0, bus.st_stall}, 32'd0);
    check("rst_ades", {31'd0, bus.st_ades}, 32'd0);
    rst_n = 1'b1;

    // sb at the top byte lane, immediate ack.
    do_store(SZ_BYTE, 32'h0000_1003, 32'hAABB_CC5A, 0);
    check("sb_wdata_const", bus.dm_wdata, 32'h5A5A_5A5A);
    check("sb_wstrb_const", {28'd0, bus.dm_wstrb}, 32'h8);
    check("sb_addr_const", bus.dm_addr, 32'h0000_1000);

    // sh then sw back to back.
    do_store(SZ_HALF, 32'h0000_2002, 32'h1234_BEEF, 0);
    check("sh_wdata_const", bus.dm_wdata, 32'hBEEF_BEEF);
    check("sh_wstrb_const", {28'd0, bus.dm_wstrb}, 32'hC);
    do_store(SZ_WORD, 32'h0000_2004, 32'hDEAD_BEEF, 0);
    check("sw_wstrb_const", {28'd0, bus.dm_wstrb}, 32'hF);
    idle_cycle();

    // Misaligned and reserved-size stores.
    do_store(SZ_WORD, 32'h0000_3002, 32'h0, 0);
    do_store(SZ_HALF, 32'h0000_3001, 32'h0, 0);
    do_store(SZ_RSVD, 32'h0000_3000, 32'h0, 0);

    // Held sw with ack delayed 5 cycles, then check no duplicate request.
    do_store(SZ_WORD, 32'h0000_3008, 32'hCAFE_F00D, 5);
    idle_cycle();
    idle_cycle();

    // Reset during REQ, then a stray ack.
    @(posedge clk); #1;
    bus.st_valid = 1'b1;
    bus.st_size  = SZ_WORD;
    bus.st_addr  = 32'h0000_5000;
    bus.st_data  = 32'h1122_3344;
    @(posedge clk); #1;
    check("rr_req_before", {31'd0, bus.dm_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_req_async", {31'd0, bus.dm_req}, 32'd0);
    check("rr_state_async", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    bus.st_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.dm_ack = 1'b1;
    @(posedge clk); #1;
    bus.dm_ack = 1'b0;
    #1;
    check("stray_ack_req", {31'd0, bus.dm_req}, 32'd0);
    check("stray_ack_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    idle_cycle();

    // Random stores into a 64-byte window.
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  rsz;
      logic [31:0] ra;
      rsz = 2'($urandom_range(0, 3));
      ra  = 32'h0000_4000 + 32'($urandom_range(0, 63));
      do_store(rsz, ra, $urandom, int'($urandom_range(0, 3)));
    end
    idle_cycle();
    for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), {24'd0, dut_mem[i]}, {24'd0, ref_mem[i]});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
